// File: rtl/poly_fill_ctrl.sv
// Polynomial-memory fill controller: sweeps enabled banks writing zero/constant/unit patterns.
// Optional read-back verification is compiled in when POLY_FILL_VERIFY_EN is defined.
module poly_fill_ctrl #(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 13,
    parameter int N_BANKS = 2,
    parameter int DEPTH   = 757
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         len,
    input  logic [1:0]                mode,
    input  logic [DATA_W-1:0]         fill_val,
    input  logic [N_BANKS-1:0]        bank_mask,
    input  logic                      wr_grant,
    input  logic                      abort,
    output logic [N_BANKS-1:0]        mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic                      mem_re,
    input  logic [N_BANKS*DATA_W-1:0] mem_rdata,
    output logic                      busy,
    output logic                      done,
    output logic                      aborted,
    output logic                      verify_err
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FILL   = 2'd1;
    localparam logic [1:0] S_VERIFY = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [ADDR_W-1:0] DEPTH_C = ADDR_W'(DEPTH);

    logic [1:0]         state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q;
    logic [ADDR_W-1:0]  len_q;
    logic [1:0]         mode_q;
    logic [DATA_W-1:0]  fill_q;
    logic [N_BANKS-1:0] mask_q;
    logic               abort_q;
    logic [ADDR_W-1:0]  len_clamped;
    logic               fill_last;

    function automatic logic [DATA_W-1:0] pattern(input logic [1:0] md,
                                                  input logic [DATA_W-1:0] fv,
                                                  input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] v;
        v = '0;
        case (md)
            2'b01:   v = fv;
            2'b10:   v = (addr == '0) ? DATA_W'(1) : '0;
            default: v = '0;
        endcase
        return v;
    endfunction

    assign len_clamped = (len > DEPTH_C) ? DEPTH_C : len;
    assign fill_last   = (cnt_q == len_q - 1'b1);

`ifdef POLY_FILL_VERIFY_EN
    logic              rd_done_q;
    logic              rd_pend_q;
    logic [ADDR_W-1:0] cmp_addr_q;
    logic              verr_q;
    logic              cmp_mismatch;
    logic              read_last;

    assign mem_re     = (state_q == S_VERIFY) && !rd_done_q;
    assign read_last  = (cnt_q == len_q - 1'b1);
    assign verify_err = verr_q;

    always_comb begin
        cmp_mismatch = 1'b0;
        for (int unsigned b = 0; b < N_BANKS; b++) begin
            if (mask_q[b] && (mem_rdata[b*DATA_W +: DATA_W] != pattern(mode_q, fill_q, cmp_addr_q)))
                cmp_mismatch = 1'b1;
        end
    end

    // Reads run one ahead of compares; rd_done_q marks the final compare-only cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_done_q  <= 1'b0;
            rd_pend_q  <= 1'b0;
            cmp_addr_q <= '0;
            verr_q     <= 1'b0;
        end else begin
            rd_pend_q  <= mem_re && !abort;
            cmp_addr_q <= cnt_q;
            if (state_q == S_IDLE && start) begin
                verr_q    <= 1'b0;
                rd_done_q <= 1'b0;
            end else if (state_q == S_VERIFY && !abort) begin
                if (mem_re && read_last)
                    rd_done_q <= 1'b1;
                if (rd_pend_q && cmp_mismatch)
                    verr_q <= 1'b1;
            end
        end
    end
`else
    logic unused_rdata;

    assign unused_rdata = ^mem_rdata;
    assign mem_re       = 1'b0;
    assign verify_err   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:
                if (start)
                    state_d = (len_clamped == '0) ? S_DONE : S_FILL;
            S_FILL:
                if (abort)
                    state_d = S_DONE;
                else if (wr_grant && fill_last)
`ifdef POLY_FILL_VERIFY_EN
                    state_d = S_VERIFY;
`else
                    state_d = S_DONE;
`endif
`ifdef POLY_FILL_VERIFY_EN
            S_VERIFY:
                if (abort || rd_done_q)
                    state_d = S_DONE;
`endif
            S_DONE:
                state_d = S_IDLE;
            default:
                state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            mode_q  <= '0;
            fill_q  <= '0;
            mask_q  <= '0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE:
                    if (start) begin
                        len_q   <= len_clamped;
                        mode_q  <= mode;
                        fill_q  <= fill_val;
                        mask_q  <= bank_mask;
                        abort_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                S_FILL:
                    if (abort) begin
                        abort_q <= 1'b1;
                        cnt_q   <= '0;
                    end else if (wr_grant) begin
                        cnt_q <= fill_last ? '0 : cnt_q + 1'b1;
                    end
`ifdef POLY_FILL_VERIFY_EN
                S_VERIFY:
                    if (abort)
                        abort_q <= 1'b1;
                    else if (mem_re && !read_last)
                        cnt_q <= cnt_q + 1'b1;
`endif
                S_DONE:
                    cnt_q <= '0;
                default: ;
            endcase
        end
    end

    // Abort wins over the grant, so the write strobe is masked in the abort cycle.
    assign mem_we    = (state_q == S_FILL && !abort && wr_grant) ? mask_q : '0;
    assign mem_addr  = cnt_q;
    assign mem_wdata = (state_q == S_FILL) ? pattern(mode_q, fill_q, cnt_q) : '0;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign aborted   = done && abort_q;

endmodule

// File: tb/tb_poly_fill_ctrl.sv
// Directed bench for poly_fill_ctrl: two-bank memory model, done-cycle timing and content checks.
// Define POLY_FILL_VERIFY_EN for both files to exercise the read-back path.
module tb_poly_fill_ctrl;

`ifdef POLY_FILL_VERIFY_EN
    localparam int VX = 1;
`else
    localparam int VX = 0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] len;
    logic [1:0]  mode;
    logic [12:0] fill_val;
    logic [1:0]  bank_mask;
    logic        wr_grant;
    logic        abort;
    logic [1:0]  mem_we;
    logic [10:0] mem_addr;
    logic [12:0] mem_wdata;
    logic        mem_re;
    logic [25:0] mem_rdata;
    logic        busy, done, aborted, verify_err;

    int nvec = 0;
    int nerr = 0;

    poly_fill_ctrl #(.ADDR_W(11), .DATA_W(13), .N_BANKS(2), .DEPTH(757)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .mode(mode),
        .fill_val(fill_val), .bank_mask(bank_mask), .wr_grant(wr_grant),
        .abort(abort), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .aborted(aborted), .verify_err(verify_err)
    );

    always #5 clk = ~clk;

    // Memory model with per-bank write counters; 13'h1FFF marks never-written words.
    logic [12:0] m0 [0:2047];
    logic [12:0] m1 [0:2047];
    logic [12:0] rd0, rd1;
    int   wc0, wc1, busy_cyc, done_cnt;
    logic oob;
    logic clr;
    logic corrupt;

    assign mem_rdata = {rd1, rd0};

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 2048; i++) begin
                m0[i] <= 13'h1FFF;
                m1[i] <= 13'h1FFF;
            end
            wc0 <= 0; wc1 <= 0; busy_cyc <= 0; done_cnt <= 0; oob <= 1'b0;
        end else begin
            if (mem_we[0]) begin m0[mem_addr] <= mem_wdata; wc0 <= wc0 + 1; end
            if (mem_we[1]) begin m1[mem_addr] <= mem_wdata; wc1 <= wc1 + 1; end
            if ((mem_we != 2'b00 || mem_re) && mem_addr >= 11'd757) oob <= 1'b1;
            if (busy) busy_cyc <= busy_cyc + 1;
            if (done) done_cnt <= done_cnt + 1;
        end
        rd0 <= m0[mem_addr];
        rd1 <= m1[mem_addr] ^ ((corrupt && mem_addr == 11'd5) ? 13'h0001 : 13'h0000);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] model(input logic [1:0] md, input logic [12:0] fv, input int a);
        if (md == 2'b01) return fv;
        if (md == 2'b10 && a == 0) return 13'd1;
        return 13'd0;
    endfunction

    function automatic int bad_cnt(input int b, input int n, input logic [1:0] md,
                                   input logic [12:0] fv, input logic en);
        int bad = 0;
        logic [12:0] e, g;
        for (int i = 0; i < 2048; i++) begin
            e = (en && i < n) ? model(md, fv, i) : 13'h1FFF;
            g = (b == 1) ? m1[i] : m0[i];
            if (g !== e) bad++;
        end
        return bad;
    endfunction

    // gmode 0: grant always high; 1: grant high on odd cycles after start.
    task automatic run(input logic [10:0] l, input logic [1:0] md, input logic [12:0] fv,
                       input logic [1:0] mk, input int gmode, input int abort_cyc,
                       input int restart_cyc, output int done_cyc, output logic ab);
        int cyc;
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        len = l; mode = md; fill_val = fv; bank_mask = mk; wr_grant = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        cyc = 1; done_cyc = -1; ab = 1'bx;
        while (cyc < 4000) begin
            wr_grant = (gmode == 0) || (cyc % 2 == 1);
            abort    = (cyc == abort_cyc);
            start    = (cyc == restart_cyc);
            if (done) begin
                done_cyc = cyc;
                ab = aborted;
                break;
            end
            @(negedge clk); cyc++;
        end
        abort = 1'b0; start = 1'b0; wr_grant = 1'b1;
        @(negedge clk);
    endtask

    int   d;
    int   dc_before;
    logic ab;

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; mode = '0; fill_val = '0; bank_mask = '0;
        wr_grant = 1'b0; abort = 1'b0; clr = 1'b0; corrupt = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_re_ab_ve", {mem_re, aborted, verify_err}, 0);
        rst = 1'b0;

        // Full-length zero fill on both banks.
        run(11'd757, 2'b00, 13'h0, 2'b11, 0, -1, -1, d, ab);
        check("t1_done_cyc", d, 758 + VX * 758);
        check("t1_aborted", ab, 0);
        check("t1_wc0", wc0, 757);
        check("t1_wc1", wc1, 757);
        check("t1_mem0", bad_cnt(0, 757, 2'b00, 13'h0, 1'b1), 0);
        check("t1_mem1", bad_cnt(1, 757, 2'b00, 13'h0, 1'b1), 0);
        check("t1_busy_cyc", busy_cyc, d);
        check("t1_busy_after", busy, 0);
        check("t1_verr", verify_err, 0);

        // Unit polynomial, bank0 only, grant toggling.
        run(11'd8, 2'b10, 13'h0AA, 2'b01, 1, -1, -1, d, ab);
        check("t2_done_cyc", d, 16 + VX * 9);
        check("t2_wc0", wc0, 8);
        check("t2_wc1", wc1, 0);
        check("t2_mem0", bad_cnt(0, 8, 2'b10, 13'h0, 1'b1), 0);
        check("t2_mem1", bad_cnt(1, 8, 2'b10, 13'h0, 1'b0), 0);

        // Over-long len clamps to DEPTH.
        run(11'd2000, 2'b01, 13'h1A5, 2'b11, 0, -1, -1, d, ab);
        check("t3_done_cyc", d, 758 + VX * 758);
        check("t3_wc0", wc0, 757);
        check("t3_oob", oob, 0);
        check("t3_mem0", bad_cnt(0, 757, 2'b01, 13'h1A5, 1'b1), 0);
        check("t3_mem1", bad_cnt(1, 757, 2'b01, 13'h1A5, 1'b1), 0);

        // Zero length: immediate done, no writes.
        run(11'd0, 2'b01, 13'h5, 2'b11, 0, -1, -1, d, ab);
        check("t4_done_cyc", d, 1);
        check("t4_writes", wc0 + wc1, 0);
        check("t4_busy_cyc", busy_cyc, 1);
        check("t4_aborted", ab, 0);

        // Abort while address 40 is presented; restart attempt mid-sweep.
        run(11'd100, 2'b01, 13'h0F0, 2'b11, 0, 41, 10, d, ab);
        check("t5_done_cyc", d, 42);
        check("t5_aborted", ab, 1);
        check("t5_wc0", wc0, 40);
        check("t5_wc1", wc1, 40);
        check("t5_mem1", bad_cnt(1, 40, 2'b01, 13'h0F0, 1'b1), 0);
        check("t5_idle_after", busy, 0);
        check("t5_done_cnt", done_cnt, 1);

        // Empty bank mask still completes.
        run(11'd4, 2'b01, 13'h7, 2'b00, 0, -1, -1, d, ab);
        check("t6_done_cyc", d, 5 + VX * 5);
        check("t6_writes", wc0 + wc1, 0);

        // Mode 11 behaves as zero fill.
        run(11'd5, 2'b11, 13'h1234, 2'b10, 0, -1, -1, d, ab);
        check("t7_done_cyc", d, 6 + VX * 6);
        check("t7_mem1", bad_cnt(1, 5, 2'b00, 13'h0, 1'b1), 0);
        check("t7_wc0", wc0, 0);

        // Asynchronous reset in the middle of a sweep.
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        len = 11'd100; mode = 2'b01; fill_val = 13'h3; bank_mask = 2'b11; wr_grant = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (19) @(negedge clk);
        dc_before = done_cnt;
        rst = 1'b1;
        #1;
        check("t8_we_async", mem_we, 0);
        check("t8_busy_async", busy, 0);
        @(negedge clk); rst = 1'b0;
        repeat (5) @(negedge clk);
        check("t8_no_done", done_cnt, dc_before);
        check("t8_wc0", wc0, 19);
        check("t8_idle", busy, 0);

`ifdef POLY_FILL_VERIFY_EN
        corrupt = 1'b1;
        run(11'd16, 2'b01, 13'h1A5, 2'b11, 0, -1, -1, d, ab);
        check("t9_done_cyc", d, 34);
        check("t9_verr", verify_err, 1);
        corrupt = 1'b0;
        run(11'd16, 2'b01, 13'h1A5, 2'b11, 0, -1, -1, d, ab);
        check("t9_clean_verr", verify_err, 0);
        check("t9_clean_cyc", d, 34);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
